// File: rtl/rename_dispatch.sv
// rename_dispatch: register rename and dispatch stage.
// Allocates a physical tag per decoded instruction from a free-tag FIFO,
// resolves source operands (committed value, produced value, same-cycle
// writeback bypass, or a dependency tag) and issues one instruction per
// cycle to the reservation station with a registered, one-cycle latency.
//
// Handshake: dec_valid/dec_ready. An instruction is taken in any cycle where
// dec_valid && dec_ready; dec_ready is combinational and never depends on
// anything downstream other than rs_full, so the decoder may hold dec_valid
// and its payload stable until it sees dec_ready high at a rising edge.
module rename_dispatch (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [2:0]  dec_op,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        writeback1_en,
    input  logic [4:0]  writeback1_vregid,
    input  logic [31:0] writeback1_val,
    input  logic        writeback2_en,
    input  logic [4:0]  writeback2_vregid,
    input  logic [31:0] writeback2_val,
    input  logic        writeback3_en,
    input  logic [4:0]  writeback3_vregid,
    input  logic [31:0] writeback3_val,
    input  logic        commit_en,
    input  logic [4:0]  commit_rd,
    input  logic [4:0]  commit_vregid,
    input  logic [31:0] commit_val,
    input  logic        rs_full,
    output logic        in_en,
    output logic [2:0]  op_type,
    output logic [4:0]  vdest_id,
    output logic        op1_dependent,
    output logic [31:0] op1,
    output logic        op2_dependent,
    output logic [31:0] op2
);

    // Architectural register file (entry 0 is never written, so reads as 0)
    logic [31:0] arch_reg [32];
    // Rename table: busy bit and producing tag per architectural register
    logic [31:0] busy;
    logic [4:0]  rtag [32];
    // Per-tag result table
    logic [31:0] done;
    logic [31:0] tag_val [32];
    // Free-tag FIFO
    logic [4:0]  free_fifo [32];
    logic [4:0]  head;
    logic [4:0]  tail;
    logic [5:0]  count;

    // Writeback buses gathered into arrays so they can be scanned in a loop
    logic [2:0]  wb_en;
    logic [4:0]  wb_id  [3];
    logic [31:0] wb_val [3];

    logic        dispatch;
    logic [4:0]  alloc_tag;
    logic [32:0] op1_res;
    logic [32:0] op2_res;

    assign wb_en     = {writeback3_en, writeback2_en, writeback1_en};
    assign wb_id[0]  = writeback1_vregid;
    assign wb_id[1]  = writeback2_vregid;
    assign wb_id[2]  = writeback3_vregid;
    assign wb_val[0] = writeback1_val;
    assign wb_val[1] = writeback2_val;
    assign wb_val[2] = writeback3_val;

    // A tag freed by this cycle's commit is only visible through count next
    // cycle, so readiness depends on the registered count alone.
    assign dec_ready = dec_valid && !rs_full && (count != 6'd0);
    assign dispatch  = dec_ready;
    assign alloc_tag = free_fifo[head];

    // Resolve one source register into {dependent, value-or-tag}.
    // Uses table contents from before this cycle's dispatch update, so a
    // source equal to the instruction's own rd sees the previous mapping.
    function automatic logic [32:0] resolve(input logic [4:0] rs);
        logic [32:0] r;
        r = '0;
        if (rs == 5'd0) begin
            r = '0;
        end else if (busy[rs]) begin
            if (done[rtag[rs]]) begin
                r = {1'b0, tag_val[rtag[rs]]};
            end else begin
                r = {1'b1, 27'd0, rtag[rs]};
                // Scan downwards so the lowest-numbered matching bus wins
                for (int n = 2; n >= 0; n--) begin
                    if (wb_en[n] && (wb_id[n] == rtag[rs])) begin
                        r = {1'b0, wb_val[n]};
                    end
                end
            end
        end else if (commit_en && (commit_rd == rs)) begin
            r = {1'b0, commit_val};
        end else begin
            r = {1'b0, arch_reg[rs]};
        end
        return r;
    endfunction

    // Operand resolution for both sources of the offered instruction
    always_comb begin
        op1_res = resolve(dec_rs1);
        op2_res = resolve(dec_rs2);
    end

    // Registered issue port: pulse in_en per dispatch, hold payload otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_en         <= 1'b0;
            op_type       <= '0;
            vdest_id      <= '0;
            op1_dependent <= 1'b0;
            op1           <= '0;
            op2_dependent <= 1'b0;
            op2           <= '0;
        end else begin
            in_en <= dispatch;
            if (dispatch) begin
                op_type       <= dec_op;
                vdest_id      <= alloc_tag;
                op1_dependent <= op1_res[32];
                op1           <= op1_res[31:0];
                op2_dependent <= op2_res[32];
                op2           <= op2_res[31:0];
            end
        end
    end

    // Rename table: commit releases a mapping it still owns; a same-cycle
    // dispatch to the same register is written last and therefore wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < 32; i++) rtag[i] <= '0;
        end else begin
            if (commit_en && (commit_rd != 5'd0) && (rtag[commit_rd] == commit_vregid)) begin
                busy[commit_rd] <= 1'b0;
            end
            if (dispatch && (dec_rd != 5'd0)) begin
                busy[dec_rd] <= 1'b1;
                rtag[dec_rd] <= alloc_tag;
            end
        end
    end

    // Per-tag results: writebacks fill in, a fresh allocation clears done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= '0;
            for (int i = 0; i < 32; i++) tag_val[i] <= '0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (wb_en[n]) begin
                    done[wb_id[n]]    <= 1'b1;
                    tag_val[wb_id[n]] <= wb_val[n];
                end
            end
            if (dispatch) begin
                done[alloc_tag] <= 1'b0;
            end
        end
    end

    // Architectural state written at retirement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) arch_reg[i] <= '0;
        end else if (commit_en && (commit_rd != 5'd0)) begin
            arch_reg[commit_rd] <= commit_val;
        end
    end

    // Free-tag FIFO: pop on dispatch, push retired tag on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) free_fifo[i] <= 5'(i);
            head  <= '0;
            tail  <= '0;
            count <= 6'd32;
        end else begin
            if (dispatch) begin
                head <= head + 5'd1;
            end
            if (commit_en) begin
                free_fifo[tail] <= commit_vregid;
                tail            <= tail + 5'd1;
            end
            case ({commit_en, dispatch})
                2'b10:   count <= count + 6'd1;
                2'b01:   count <= count - 6'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/rename_dispatch.md
RENAME_DISPATCH -- requirements
Module: rename_dispatch

Interface
REQ-001 clk  input  1  system clock; all state updates on the rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 dec_valid  input  1  decoded instruction offered.
REQ-004 dec_ready  output  1  combinational; dispatch accepted this cycle.
REQ-005 dec_op  input  3  operation code, passed through to op_type.
REQ-006 dec_rs1, dec_rs2, dec_rd  input  5 each  architectural source and destination registers.
REQ-007 writebackN_en, writebackN_vregid, writebackN_val (N=1..3)  input  1/5/32  snooped result buses.
REQ-008 commit_en, commit_rd, commit_vregid, commit_val  input  1/5/5/32  in-order retirement of one instruction.
REQ-009 rs_full  input  1  downstream reservation station full.
REQ-010 in_en, op_type, vdest_id  output  1/3/5  registered issue to the reservation station.
REQ-011 op1_dependent, op1, op2_dependent, op2  output  1/32/1/32  registered operands; when dependent, bits [4:0] carry the producer tag and bits [31:5] are 0.

Function
REQ-012 State:
- arch_reg[32]x32, with x0 reading as 0 and never written.
- rename table per arch reg: busy bit + tag[4:0].
- per-tag table: done bit + value[31:0].
- free-tag FIFO: 32 entries, head/tail 5-bit (wrap 31->0), count 6-bit.
REQ-013 dec_ready = dec_valid && !rs_full && count != 0.
REQ-014 Dispatch (dec_ready=1) pops tag T from head; next cycle in_en=1, vdest_id=T, op_type=dec_op (1-cycle latency).
- Otherwise in_en=0 next cycle; the other outputs hold.
REQ-015 Dispatch with dec_rd != 0 sets rename[dec_rd] = {busy=1, tag=T}.
- dec_rd = 0 still consumes a tag; rename table unchanged.
REQ-016 Dispatch clears done[T].
REQ-017 Operand resolution, per source rs, in priority order:
- rs = 0: value 0, not dependent.
- rename busy with tag t and done[t]: value[t].
- rename busy with tag t and any writebackN_en matching t this cycle: that writeback's val, lowest N first.
- rename busy otherwise: dependent, tag t.
- not busy, commit_en with commit_rd = rs this cycle: commit_val.
- not busy otherwise: arch_reg[rs].
REQ-018 Rename lookups for operands use table contents before this cycle's dispatch update.
- Consequence: rs = rd of the same instruction reads the old mapping.
REQ-019 Each writebackN_en sets done[vregid] = 1 and value[vregid] = val.
- Writebacks to distinct tags in the same cycle all apply.
REQ-020 commit_en, commit_rd != 0:
- arch_reg[commit_rd] <= commit_val.
- rename[commit_rd].busy <= 0 only if rename[commit_rd].tag == commit_vregid and no same-cycle dispatch renames commit_rd; otherwise the dispatch mapping wins.
REQ-021 commit_en pushes commit_vregid at tail, including when commit_rd = 0.
REQ-022 count update: +1 on commit_en, -1 on dispatch, net 0 when both occur.
- A tag committed this cycle is not dispatchable until the next cycle.
REQ-023 count never exceeds 32; a commit with count = 32 is a protocol error and has no defined behaviour.

Reset
REQ-024 Reset asserted, asynchronously:
- in_en = 0; all other outputs = 0.
- all busy = 0, all done = 0, arch_reg = 0.
- free FIFO holds tags 0..31 in order; head = 0, tail = 0, count = 32.
REQ-025 Reset asserted mid-operation discards all in-flight mappings and queued tags.
- The first dispatch after reset receives tag 0.

Verification
REQ-026 Reset, then dispatch op=3 rs1=1 rs2=2 rd=3 -> next cycle in_en=1, vdest_id=0, op1=op2=0, both not dependent.
REQ-027 RAW: dispatch rd=5 (tag 0), then rs1=5 rd=6 -> op1_dependent=1, op1=0x00000000 (tag 0), vdest_id=1.
REQ-028 Same-cycle bypass: tag 0 busy, writeback2 vregid=0 val=0x1234 in the cycle rs1=5 dispatches -> op1_dependent=0, op1=0x1234.
REQ-029 Pool exhaustion and backpressure:
- 32 dispatches with no commit -> dec_ready=0 while count=0.
- one commit_vregid=7 -> next dispatch gets tag 7.
- rs_full=1 -> dec_ready=0 and in_en=0.
REQ-030 Commit and rename of the same register in one cycle:
- commit rd=5 tag 0 val=9 while dispatching rd=5 -> rename[5] busy with the new tag.
- a later read of rs1=5 is dependent on the new tag; arch_reg[5]=9.
